// File: rtl/turf_acknack_pkg.sv
// turf_acknack_pkg: shared constants, FSM encodings and helpers for the TURF ack/nack port
package turf_acknack_pkg;
   localparam int          OPEN_BIT        = 62;
   localparam logic [63:0] ACK_CHECK_BITS  = 64'h800000FF_FFF00000;
   localparam logic [63:0] NACK_CHECK_BITS = 64'h000000FF_FFFFFFFF;
   localparam logic [15:0] REPLY_LEN       = 16'd16;
   localparam int          AN_ALLOW        = 47;
   localparam int          AN_FULL         = 46;
   localparam int          AN_FRAG_LSB     = 32;
   localparam int          AN_FRAG_W       = 11;
   localparam int          AN_TAG_W        = 32;
   localparam logic [2:0]  S_IDLE          = 3'd0;
   localparam logic [2:0]  S_CHECK         = 3'd1;
   localparam logic [2:0]  S_WRITE         = 3'd2;
   localparam logic [2:0]  S_SKIP_ONE      = 3'd3;
   localparam logic [2:0]  S_SKIP_REST     = 3'd4;
   localparam logic [2:0]  S_DUMP          = 3'd5;
   localparam logic [2:0]  S_HDR           = 3'd6;
   localparam logic [2:0]  S_RESP          = 3'd7;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/turf_acknack_dedup.sv
// turf_acknack_dedup: shift-register history of recently accepted masked qwords with combinational match
module turf_acknack_dedup #(
   parameter int DEDUP_DEPTH = 4
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [63:0] din_i,
   output logic        match_o
);
   logic [63:0]            entry_q [DEDUP_DEPTH];
   logic [63:0]            entry_d [DEDUP_DEPTH];
   logic [DEDUP_DEPTH-1:0] valid_q, valid_d;

   always_comb begin
      entry_d = entry_q;
      valid_d = valid_q;
      match_o = 1'b0;
      for (int i = 0; i < DEDUP_DEPTH; i++) match_o = match_o | (valid_q[i] && entry_q[i] == din_i);
      if (push_i) begin
         entry_d[0] = din_i;
         valid_d[0] = 1'b1;
         for (int i = 1; i < DEDUP_DEPTH; i++) begin
            entry_d[i] = entry_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
      end
      if (clear_i) valid_d = '0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_q <= '0;
         for (int i = 0; i < DEDUP_DEPTH; i++) entry_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end
endmodule

// File: rtl/turf_acknack_port_v2.sv
// turf_acknack_port_v2: filters request qwords into the ack/nack stream and answers each request with a one-qword reply
module turf_acknack_port_v2
   import turf_acknack_pkg::*;
#(
   parameter logic [63:0] CHECK_BITS  = ACK_CHECK_BITS,
   parameter int          DEDUP_DEPTH = 4,
   parameter int          MAX_ENTRIES = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        event_open_i,
   input  logic [9:0]  nfragment_count_i,
   input  logic [63:0] s_udphdr_tdata,
   input  logic        s_udphdr_tvalid,
   output logic        s_udphdr_tready,
   input  logic [63:0] s_udpdata_tdata,
   input  logic [7:0]  s_udpdata_tkeep,
   input  logic        s_udpdata_tlast,
   input  logic        s_udpdata_tvalid,
   output logic        s_udpdata_tready,
   output logic [63:0] m_udphdr_tdata,
   output logic        m_udphdr_tvalid,
   input  logic        m_udphdr_tready,
   output logic [63:0] m_udpdata_tdata,
   output logic [7:0]  m_udpdata_tkeep,
   output logic        m_udpdata_tlast,
   output logic        m_udpdata_tvalid,
   input  logic        m_udpdata_tready,
   output logic [47:0] m_acknack_tdata,
   output logic        m_acknack_tvalid,
   input  logic        m_acknack_tready,
   output logic [15:0] dup_count_o,
   output logic [15:0] overflow_count_o
);
   localparam logic [63:0] MASK  = CHECK_BITS & ~(64'd1 << OPEN_BIT);
   localparam logic [7:0]  MAX_E = 8'(MAX_ENTRIES);

   logic [2:0]  state_q, state_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] port_q, port_d, dup_q, dup_d, ovf_q, ovf_d;
   logic [7:0]  entries_q, entries_d;
   logic        first_q, first_d, full_nack_q, full_nack_d, open_q;
   logic [10:0] frag_q, frag_d;
   logic [63:0] last_q, last_d, masked;
   logic        match, push, unused_hdr;

   assign masked     = s_udpdata_tdata & MASK;
   assign unused_hdr = ^s_udphdr_tdata[15:0];

   turf_acknack_dedup #(.DEDUP_DEPTH(DEDUP_DEPTH)) u_dedup (
      .aclk   (aclk),
      .aresetn(aresetn),
      .clear_i(!event_open_i),
      .push_i (push),
      .din_i  (masked),
      .match_o(match)
   );

   always_comb begin
      state_d          = state_q;
      ip_d             = ip_q;
      port_d           = port_q;
      entries_d        = entries_q;
      first_d          = first_q;
      full_nack_d      = full_nack_q;
      last_d           = last_q;
      dup_d            = dup_q;
      ovf_d            = ovf_q;
      push             = 1'b0;
      s_udphdr_tready  = 1'b0;
      s_udpdata_tready = 1'b0;
      m_acknack_tvalid = 1'b0;
      m_udphdr_tvalid  = 1'b0;
      m_udpdata_tvalid = 1'b0;
      frag_d = (event_open_i && !open_q) ? {1'b0, nfragment_count_i} + 11'd1 : frag_q;
      case (state_q)
         S_IDLE: begin
            s_udphdr_tready = 1'b1;
            if (s_udphdr_tvalid) begin
               ip_d      = s_udphdr_tdata[63:32];
               port_d    = s_udphdr_tdata[31:16];
               entries_d = '0;
               first_d   = 1'b1;
               state_d   = S_CHECK;
            end
         end
         S_CHECK: if (s_udpdata_tvalid) begin
            full_nack_d = s_udpdata_tdata[19:0] == 20'hFFFFF;
            // overflow is tested before dedup so a qword never counts twice
            if (s_udpdata_tkeep != 8'hFF) state_d = first_q ? S_DUMP : S_SKIP_REST;
            else if (!event_open_i) state_d = S_SKIP_REST;
            else if (entries_q == MAX_E) begin
               ovf_d   = sat_inc(ovf_q);
               state_d = S_SKIP_ONE;
            end else if (match) begin
               dup_d   = sat_inc(dup_q);
               state_d = S_SKIP_ONE;
            end else state_d = S_WRITE;
         end
         S_WRITE: begin
            m_acknack_tvalid = 1'b1;
            s_udpdata_tready = m_acknack_tready;
            if (m_acknack_tready && s_udpdata_tvalid) begin
               push      = 1'b1;
               last_d    = masked;
               entries_d = entries_q + 8'd1;
               first_d   = 1'b0;
               state_d   = s_udpdata_tlast ? S_HDR : S_CHECK;
            end
         end
         S_SKIP_ONE: begin
            s_udpdata_tready = 1'b1;
            if (s_udpdata_tvalid) begin
               first_d = 1'b0;
               state_d = s_udpdata_tlast ? S_HDR : S_CHECK;
            end
         end
         S_SKIP_REST: begin
            s_udpdata_tready = 1'b1;
            if (s_udpdata_tvalid && s_udpdata_tlast) state_d = S_HDR;
         end
         S_DUMP: begin
            s_udpdata_tready = 1'b1;
            if (s_udpdata_tvalid && s_udpdata_tlast) state_d = S_IDLE;
         end
         S_HDR: begin
            m_udphdr_tvalid = 1'b1;
            if (m_udphdr_tready) state_d = S_RESP;
         end
         default: begin
            m_udpdata_tvalid = 1'b1;
            if (m_udpdata_tready) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      m_acknack_tdata                               = '0;
      m_acknack_tdata[AN_ALLOW]                     = s_udpdata_tdata[63];
      m_acknack_tdata[AN_FULL]                      = full_nack_q;
      m_acknack_tdata[AN_FRAG_LSB +: AN_FRAG_W]     = frag_q;
      m_acknack_tdata[AN_TAG_W-1:0]                 = s_udpdata_tdata[AN_TAG_W-1:0];
   end

   assign m_udphdr_tdata   = {ip_q, port_q, REPLY_LEN};
   assign m_udpdata_tdata  = (last_q & MASK) | ({63'd0, event_open_i} << OPEN_BIT);
   assign m_udpdata_tkeep  = 8'hFF;
   assign m_udpdata_tlast  = 1'b1;
   assign dup_count_o      = dup_q;
   assign overflow_count_o = ovf_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         ip_q        <= '0;
         port_q      <= '0;
         entries_q   <= '0;
         first_q     <= 1'b0;
         full_nack_q <= 1'b0;
         open_q      <= 1'b0;
         frag_q      <= '0;
         last_q      <= '0;
         dup_q       <= '0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         ip_q        <= ip_d;
         port_q      <= port_d;
         entries_q   <= entries_d;
         first_q     <= first_d;
         full_nack_q <= full_nack_d;
         open_q      <= event_open_i;
         frag_q      <= frag_d;
         last_q      <= last_d;
         dup_q       <= dup_d;
         ovf_q       <= ovf_d;
      end
   end
endmodule

// File: tb/tb_turf_acknack_port_v2.sv
// tb_turf_acknack_port_v2: table vectors, corner sequences and random packets against a queue-based model
module tb_turf_acknack_port_v2;
   localparam int          DEPTH = 4;
   localparam int          MAXE  = 6;
   localparam logic [63:0] MASK  = 64'h800000FF_FFF00000;

   logic        aclk = 1'b0, aresetn = 1'b0, event_open_i = 1'b0;
   logic [9:0]  nfragment_count_i = '0;
   logic [63:0] s_udphdr_tdata = '0, s_udpdata_tdata = '0;
   logic        s_udphdr_tvalid = 1'b0, s_udpdata_tvalid = 1'b0, s_udpdata_tlast = 1'b0;
   logic [7:0]  s_udpdata_tkeep = 8'hFF;
   logic        s_udphdr_tready, s_udpdata_tready;
   logic [63:0] m_udphdr_tdata, m_udpdata_tdata;
   logic        m_udphdr_tvalid, m_udpdata_tvalid, m_udpdata_tlast;
   logic [7:0]  m_udpdata_tkeep;
   logic        m_udphdr_tready = 1'b1, m_udpdata_tready = 1'b1, m_acknack_tready = 1'b1;
   logic [47:0] m_acknack_tdata;
   logic        m_acknack_tvalid;
   logic [15:0] dup_count_o, overflow_count_o;

   always #5 aclk = ~aclk;

   turf_acknack_port_v2 #(.DEDUP_DEPTH(DEPTH), .MAX_ENTRIES(MAXE)) dut (
      .aclk(aclk), .aresetn(aresetn), .event_open_i(event_open_i), .nfragment_count_i(nfragment_count_i),
      .s_udphdr_tdata(s_udphdr_tdata), .s_udphdr_tvalid(s_udphdr_tvalid), .s_udphdr_tready(s_udphdr_tready),
      .s_udpdata_tdata(s_udpdata_tdata), .s_udpdata_tkeep(s_udpdata_tkeep), .s_udpdata_tlast(s_udpdata_tlast),
      .s_udpdata_tvalid(s_udpdata_tvalid), .s_udpdata_tready(s_udpdata_tready),
      .m_udphdr_tdata(m_udphdr_tdata), .m_udphdr_tvalid(m_udphdr_tvalid), .m_udphdr_tready(m_udphdr_tready),
      .m_udpdata_tdata(m_udpdata_tdata), .m_udpdata_tkeep(m_udpdata_tkeep), .m_udpdata_tlast(m_udpdata_tlast),
      .m_udpdata_tvalid(m_udpdata_tvalid), .m_udpdata_tready(m_udpdata_tready),
      .m_acknack_tdata(m_acknack_tdata), .m_acknack_tvalid(m_acknack_tvalid), .m_acknack_tready(m_acknack_tready),
      .dup_count_o(dup_count_o), .overflow_count_o(overflow_count_o)
   );

   int checks = 0, failures = 0, bp_mode = 0;
   logic [47:0] got_ack[$];
   logic [63:0] got_hdr[$], got_rd[$];

   always @(posedge aclk) begin
      if (aresetn && m_acknack_tvalid && m_acknack_tready) got_ack.push_back(m_acknack_tdata);
      if (aresetn && m_udphdr_tvalid && m_udphdr_tready) got_hdr.push_back(m_udphdr_tdata);
      if (aresetn && m_udpdata_tvalid && m_udpdata_tready) got_rd.push_back(m_udpdata_tdata);
   end

   always @(posedge aclk) begin
      #1;
      m_acknack_tready = (bp_mode == 2) ? 1'b0 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_udphdr_tready  = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      m_udpdata_tready = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // model state: history is a plain queue of accepted masked qwords, newest at the back
   logic [63:0] hist[$];
   int          dup_m = 0, ovf_m = 0;
   logic [63:0] last_m = '0, exp_rd = '0;
   logic [10:0] frag_m = '0;
   bit          open_m = 1'b0, exp_reply = 1'b0;
   logic [47:0] exp_ack[$];

   task automatic model_pkt(input logic [63:0] d[$], input logic [7:0] k[$]);
      int n = 0;
      exp_ack.delete();
      exp_reply = 1'b1;
      for (int i = 0; i < d.size(); i++) begin
         logic [63:0] m;
         bit          seen;
         m    = d[i] & MASK;
         seen = 1'b0;
         if (k[i] != 8'hFF) begin
            exp_reply = (i != 0);
            break;
         end
         if (!open_m) break;
         if (n == MAXE) begin
            ovf_m = (ovf_m < 65535) ? ovf_m + 1 : ovf_m;
            continue;
         end
         foreach (hist[j]) if (hist[j] == m) seen = 1'b1;
         if (seen) begin
            dup_m = (dup_m < 65535) ? dup_m + 1 : dup_m;
            continue;
         end
         exp_ack.push_back({d[i][63], d[i][19:0] == 20'hFFFFF, 3'b000, frag_m, d[i][31:0]});
         hist.push_back(m);
         if (hist.size() > DEPTH) void'(hist.pop_front());
         last_m = m;
         n++;
      end
      exp_rd = last_m | (open_m ? 64'h40000000_00000000 : 64'd0);
   endtask

   task automatic wait_hs(input bit is_hdr);
      int t = 0;
      do begin
         @(negedge aclk);
         t++;
      end while (!(is_hdr ? s_udphdr_tready : s_udpdata_tready) && t < 500);
      if (t >= 500) chk("handshake_timeout", 64'(t), 64'd0);
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge aclk);
         t++;
      end while (!s_udphdr_tready && t < 500);
      if (t >= 500) chk("idle_timeout", 64'(t), 64'd0);
      @(posedge aclk);
      #1;
   endtask

   task automatic drive_pkt(input logic [63:0] hdr, input logic [63:0] d[$], input logic [7:0] k[$]);
      s_udphdr_tdata  = hdr;
      s_udphdr_tvalid = 1'b1;
      wait_hs(1'b1);
      s_udphdr_tvalid = 1'b0;
      for (int i = 0; i < d.size(); i++) begin
         s_udpdata_tdata  = d[i];
         s_udpdata_tkeep  = k[i];
         s_udpdata_tlast  = (i == d.size() - 1);
         s_udpdata_tvalid = 1'b1;
         wait_hs(1'b0);
      end
      s_udpdata_tvalid = 1'b0;
      s_udpdata_tlast  = 1'b0;
      wait_idle();
   endtask

   task automatic check_pkt(input logic [63:0] hdr);
      chk("ack_count", 64'(got_ack.size()), 64'(exp_ack.size()));
      for (int i = 0; i < got_ack.size() && i < exp_ack.size(); i++) chk("ack_data", 64'(got_ack[i]), 64'(exp_ack[i]));
      chk("reply_count", 64'(got_rd.size()), 64'(exp_reply));
      chk("reply_hdr_count", 64'(got_hdr.size()), 64'(exp_reply));
      if (got_rd.size() > 0 && exp_reply) chk("reply_data", got_rd[0], exp_rd);
      if (got_hdr.size() > 0 && exp_reply) chk("reply_hdr", got_hdr[0], {hdr[63:16], 16'd16});
      chk("dup_count", 64'(dup_count_o), 64'(dup_m));
      chk("overflow_count", 64'(overflow_count_o), 64'(ovf_m));
      got_ack.delete();
      got_hdr.delete();
      got_rd.delete();
   endtask

   task automatic run_pkt(input logic [63:0] hdr, input logic [63:0] d[$], input logic [7:0] k[$], input int exp_n);
      model_pkt(d, k);
      drive_pkt(hdr, d, k);
      if (exp_n >= 0) chk("ack_count_expected", 64'(got_ack.size()), 64'(exp_n));
      check_pkt(hdr);
   endtask

   task automatic set_open(input bit o, input logic [9:0] nf);
      nfragment_count_i = nf;
      if (o && !open_m) frag_m = {1'b0, nf} + 11'd1;
      if (!o) hist.delete();
      open_m       = o;
      event_open_i = o;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic chk_reset();
      chk("rst_hdr_tready", 64'(s_udphdr_tready), 64'd1);
      chk("rst_data_tready", 64'(s_udpdata_tready), 64'd0);
      chk("rst_ack_tvalid", 64'(m_acknack_tvalid), 64'd0);
      chk("rst_hdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
      chk("rst_rd_tvalid", 64'(m_udpdata_tvalid), 64'd0);
      chk("rst_dup", 64'(dup_count_o), 64'd0);
      chk("rst_ovf", 64'(overflow_count_o), 64'd0);
      chk("rst_reply_data", m_udpdata_tdata, 64'd0);
   endtask

   typedef struct {
      bit          open;
      logic [63:0] d;
      logic [7:0]  k;
      bit          ack;
      bit          reply;
      logic [63:0] rd;
      int          dup;
   } vec_t;

   vec_t        tbl[8];
   logic [63:0] dq[$], pool[8];
   logic [7:0]  kq[$];

   initial begin
      tbl[0] = '{1'b1, 64'h00000012_34500000, 8'hFF, 1'b1, 1'b1, 64'h40000012_34500000, 0};
      tbl[1] = '{1'b1, 64'h00000012_34500000, 8'hFF, 1'b0, 1'b1, 64'h40000012_34500000, 1};
      tbl[2] = '{1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1, 1'b1, 64'hC00000FF_FFF00000, 1};
      tbl[3] = '{1'b0, 64'h00000012_34500000, 8'hFF, 1'b0, 1'b1, 64'h800000FF_FFF00000, 1};
      tbl[4] = '{1'b0, 64'h00000012_34500000, 8'h0F, 1'b0, 1'b0, 64'h0, 1};
      tbl[5] = '{1'b1, 64'h00000012_34500000, 8'hFF, 1'b1, 1'b1, 64'h40000012_34500000, 1};
      tbl[6] = '{1'b1, 64'h12345678_9ABCDEF0, 8'hFF, 1'b1, 1'b1, 64'h40000078_9AB00000, 1};
      tbl[7] = '{1'b1, 64'h00000078_9AB12345, 8'hFF, 1'b0, 1'b1, 64'h40000078_9AB00000, 2};

      repeat (3) @(posedge aclk);
      #1;
      chk_reset();
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      foreach (tbl[i]) begin
         if (tbl[i].open != open_m) set_open(tbl[i].open, 10'd1023);
         dq = {tbl[i].d};
         kq = {tbl[i].k};
         model_pkt(dq, kq);
         drive_pkt(64'hC0A80001_1F900000 + 64'(i), dq, kq);
         chk("tbl_ack_count", 64'(got_ack.size()), 64'(tbl[i].ack));
         if (got_ack.size() > 0 && tbl[i].ack)
            chk("tbl_ack_data", 64'(got_ack[0]), 64'({tbl[i].d[63], tbl[i].d[19:0] == 20'hFFFFF, 3'b000, 11'd1024, tbl[i].d[31:0]}));
         chk("tbl_reply_count", 64'(got_rd.size()), 64'(tbl[i].reply));
         if (got_rd.size() > 0 && tbl[i].reply) chk("tbl_reply_data", got_rd[0], tbl[i].rd);
         chk("tbl_dup_count", 64'(dup_count_o), 64'(tbl[i].dup));
         got_ack.delete();
         got_hdr.delete();
         got_rd.delete();
      end

      dq = {64'h00000055_12300000, 64'h00000055_12300000};
      kq = {8'hFF, 8'hFF};
      run_pkt(64'h0A000001_12340000, dq, kq, 1);

      dq.delete();
      kq.delete();
      for (int i = 1; i <= 5; i++) begin
         dq.push_back({32'h000000A0 + 32'(i), 32'h0});
         kq.push_back(8'hFF);
      end
      dq.push_back(dq[0]);
      kq.push_back(8'hFF);
      run_pkt(64'h0A000002_12340000, dq, kq, 6);

      dq.delete();
      kq.delete();
      for (int i = 1; i <= 8; i++) begin
         dq.push_back({32'h000000B0 + 32'(i), 32'h0});
         kq.push_back(8'hFF);
      end
      run_pkt(64'h0A000003_12340000, dq, kq, 6);
      chk("overflow_two", 64'(overflow_count_o), 64'd2);

      dq = {64'h000000C1_00000000, 64'h000000C2_00000000};
      kq = {8'h0F, 8'hFF};
      run_pkt(64'h0A000004_12340000, dq, kq, 0);
      set_open(1'b0, 10'd0);
      dq = {64'h000000C3_00000000};
      kq = {8'hFF};
      run_pkt(64'h0A000005_12340000, dq, kq, 0);
      set_open(1'b1, 10'd5);

      // acknack sink stalls: the payload beat must stay held, then be delivered once
      bp_mode = 2;
      dq = {64'h800000D1_FFFFFFFF};
      kq = {8'hFF};
      model_pkt(dq, kq);
      s_udphdr_tdata  = 64'h0A000006_12340000;
      s_udphdr_tvalid = 1'b1;
      wait_hs(1'b1);
      s_udphdr_tvalid  = 1'b0;
      s_udpdata_tdata  = dq[0];
      s_udpdata_tkeep  = 8'hFF;
      s_udpdata_tlast  = 1'b1;
      s_udpdata_tvalid = 1'b1;
      repeat (10) begin
         @(negedge aclk);
         chk("stall_tready_low", 64'(s_udpdata_tready), 64'd0);
      end
      chk("stall_ack_tvalid", 64'(m_acknack_tvalid), 64'd1);
      @(posedge aclk);
      #1;
      bp_mode = 0;
      wait_hs(1'b0);
      s_udpdata_tvalid = 1'b0;
      s_udpdata_tlast  = 1'b0;
      wait_idle();
      chk("stall_ack_count", 64'(got_ack.size()), 64'd1);
      check_pkt(64'h0A000006_12340000);

      bp_mode = 2;
      s_udphdr_tdata  = 64'h0A000007_12340000;
      s_udphdr_tvalid = 1'b1;
      wait_hs(1'b1);
      s_udphdr_tvalid  = 1'b0;
      s_udpdata_tdata  = 64'h000000E1_00000000;
      s_udpdata_tlast  = 1'b0;
      s_udpdata_tvalid = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      aresetn          = 1'b0;
      event_open_i     = 1'b0;
      s_udpdata_tvalid = 1'b0;
      @(posedge aclk);
      #1;
      chk_reset();
      aresetn = 1'b1;
      bp_mode = 0;
      hist.delete();
      dup_m  = 0;
      ovf_m  = 0;
      last_m = '0;
      frag_m = '0;
      open_m = 1'b0;
      repeat (20) @(posedge aclk);
      #1;
      chk("rst_mid_no_reply", 64'(got_hdr.size() + got_rd.size()), 64'd0);
      chk("rst_mid_no_ack", 64'(got_ack.size()), 64'd0);
      chk("rst_mid_idle", 64'(s_udphdr_tready), 64'd1);
      set_open(1'b1, 10'd77);

      bp_mode = 1;
      for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom};
      for (int p = 0; p < 80; p++) begin
         if ($urandom_range(0, 9) == 0) set_open(!open_m, 10'($urandom));
         dq.delete();
         kq.delete();
         for (int i = 0, n = $urandom_range(1, 8); i < n; i++) begin
            dq.push_back(($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 7)] : {$urandom, $urandom});
            kq.push_back(($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 254)) : 8'hFF);
         end
         run_pkt({$urandom, $urandom}, dq, kq, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/turf_acknack_port_v2.md
TURF_ACKNACK_PORT_V2 -- requirements
Module: turf_acknack_port_v2

Interface
REQ-001 SHALL have parameter CHECK_BITS, default 64'h800000FF_FFF00000: compare/echo mask; NACK instance uses 64'h000000FF_FFFFFFFF; bit 62 forced to 0 internally (OPEN bit).
REQ-002 SHALL have parameter DEDUP_DEPTH, default 4, range 1..8: number of most recent accepted masked qwords kept for duplicate rejection.
REQ-003 SHALL have parameter MAX_ENTRIES, default 16, range 1..255: maximum qwords forwarded to m_acknack per request packet.
REQ-004 aclk  in  1  sole clock; all logic on its rising edge.
REQ-005 aresetn  in  1  asynchronous, active-low reset.
REQ-006 event_open_i  in  1  event window open; low clears dedup history.
REQ-007 nfragment_count_i  in  10  fragment count minus one, latched on event_open_i rising edge.
REQ-008 s_udphdr_tdata/tvalid/tready  in/in/out  64/1/1  request header: IP [63:32], port [31:16].
REQ-009 s_udpdata_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  64/8/1/1/1  request payload.
REQ-010 m_udphdr_tdata/tvalid/tready  out/out/in  64/1/1  reply header {ip, port, 16'd16}.
REQ-011 m_udpdata_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  64/8/1/1/1  one-qword reply; tkeep 8'hFF, tlast 1.
REQ-012 m_acknack_tdata/tvalid/tready  out/out/in  48/1/1  {allow=tdata[63], full_nack, 3'b0, nack_frag_count[10:0], tdata[31:0]}.
REQ-013 dup_count_o  out  16  saturating count of qwords rejected as duplicates.
REQ-014 overflow_count_o  out  16  saturating count of qwords skipped beyond MAX_ENTRIES.

Function
REQ-015 FSM states SHALL be IDLE, CHECK, WRITE, SKIP_ONE, SKIP_REST, DUMP, HDR, RESP.
REQ-016 IDLE: s_udphdr_tready=1; on handshake latch IP/port, clear entry counter, go CHECK.
REQ-017 CHECK (s_udpdata_tready=0) on tvalid, priority order: first qword with tkeep!=FF -> DUMP; later qword with tkeep!=FF -> SKIP_REST; event_open_i=0 -> SKIP_REST; entry count==MAX_ENTRIES -> SKIP_ONE with overflow increment; masked tdata matches any valid history entry -> SKIP_ONE with dup increment; else WRITE.
REQ-018 WRITE: m_acknack_tvalid=1, s_udpdata_tready=m_acknack_tready; on handshake push masked qword into history (oldest evicted), store as last_store, increment entry count; tlast -> HDR, else CHECK.
REQ-019 SKIP_ONE: tready=1 for exactly one beat; tlast -> HDR, else CHECK (dedup is per-qword; later qwords still processed).
REQ-020 SKIP_REST: tready=1 until tlast beat, then HDR.
REQ-021 DUMP: tready=1 until tlast beat, then IDLE; no reply.
REQ-022 HDR: m_udphdr_tvalid=1 until handshake -> RESP; RESP: m_udpdata_tvalid=1 until handshake -> IDLE.
REQ-023 m_udpdata_tdata SHALL equal (last_store & mask) | (event_open_i<<62).
REQ-024 full_nack SHALL be registered as (tdata[19:0]==20'hFFFFF) in CHECK on tvalid.
REQ-025 nack_frag_count SHALL be nfragment_count_i+1 (11 bits, 1023 -> 1024).
REQ-026 Counters SHALL saturate at 16'hFFFF; simultaneous dup and overflow conditions count only overflow.
REQ-027 event_open_i falling SHALL clear all history valid bits next cycle; last_store retained.
REQ-028 History match SHALL be combinational against registered entries; no added latency beyond one CHECK cycle per qword.

Reset
REQ-029 On aresetn low: state=IDLE, history invalid, last_store=0, counters=0, full_nack=0, nack_frag_count=0; all tvalid and tready outputs 0 except s_udphdr_tready=1.
REQ-030 Reset mid-packet SHALL abandon the packet without reply; release resumes in IDLE.

Structure
REQ-031 Shared package turf_acknack_pkg SHALL hold OPEN_BIT=62, ACK_CHECK_BITS, NACK_CHECK_BITS, reply length 16 and acknack field offsets.
REQ-032 History SHALL be sub-module turf_acknack_dedup (push, clear, match, DEDUP_DEPTH parameter).

Verification
REQ-033 Open event, one-qword request 0x0000_0012_3450_0000 -> one acknack, reply tdata = masked value | bit62.
REQ-034 Same qword twice in one packet, DEDUP_DEPTH=4 -> one acknack, dup_count_o=1, reply still sent.
REQ-035 Five distinct qwords, DEDUP_DEPTH=4, then resend first -> accepted again (evicted), six acknacks total.
REQ-036 MAX_ENTRIES=2, packet of 4 qwords -> two acknacks, overflow_count_o=2.
REQ-037 First qword tkeep=8'h0F -> no acknack, no reply, back to IDLE; event closed -> reply bit62=0, no acknack.
REQ-038 m_acknack_tready held low 10 cycles -> s_udpdata_tready low throughout, no beat lost.
